// File: rtl/alu_issue.sv
// alu_issue: issue stage in front of the 32-bit integer ALU.
// It decodes RV32I OP / OP-IMM into ALU controls, latches the operands and
// presents each op through a two-entry (output + skid) valid/ready buffer.
// Optional feature: define ALU_ISSUE_FWD_EN to add writeback forwarding
// (wb_valid/wb_rd/wb_data ports).
//
// Handshake: a transfer happens on an edge where valid && ready are both high.
// Valid never drops and payload never changes until the transfer happens.
// in_ready depends only on the skid flag and reset, never on out_ready.
module alu_issue #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            reset,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [31:0]     in_instr,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   input  logic [XLEN-1:0] rs1_data,
   input  logic [XLEN-1:0] rs2_data,
`ifdef ALU_ISSUE_FWD_EN
   input  logic            wb_valid,
   input  logic [4:0]      wb_rd,
   input  logic [XLEN-1:0] wb_data,
`endif
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] out_a,
   output logic [XLEN-1:0] out_b,
   output logic [2:0]      out_funct3,
   output logic            out_funct7_5b,
   output logic [4:0]      out_rd,
   output logic            out_illegal
);

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] F7_ZERO    = 7'b0000000;
   localparam logic [6:0] F7_ALT     = 7'b0100000;

   typedef struct packed {
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [2:0]      funct3;
      logic            funct7_5b;
      logic [4:0]      rd;
      logic            illegal;
   } entry_t;

   entry_t dec;
   entry_t out_q;
   entry_t skid_q;
   logic   out_valid_q;
   logic   skid_valid_q;

   logic [6:0]      opcode;
   logic [2:0]      funct3;
   logic [6:0]      funct7;
   logic [XLEN-1:0] imm_sext;
   logic [XLEN-1:0] a_src;
   logic [XLEN-1:0] b_src;
   logic            accept;
   logic            drain;

   assign opcode   = in_instr[6:0];
   assign funct3   = in_instr[14:12];
   assign funct7   = in_instr[31:25];
   assign rs1_addr = in_instr[19:15];
   assign rs2_addr = in_instr[24:20];
   assign imm_sext = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};

   // Reset gates in_ready combinationally so it reads 0 while reset is high and
   // 1 as soon as reset drops (the skid flag is already clear by then).
   assign in_ready = !skid_valid_q && !reset;
   assign accept   = in_valid && in_ready;
   assign drain    = out_valid_q && out_ready;

   // Operand source selection, with optional writeback bypass.
   always_comb begin
      a_src = rs1_data;
      b_src = rs2_data;
`ifdef ALU_ISSUE_FWD_EN
      if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs1_addr)) a_src = wb_data;
      if (wb_valid && (wb_rd != 5'd0) && (wb_rd == rs2_addr)) b_src = wb_data;
`endif
   end

   // Decode the incoming word; illegal encodings zero every payload field.
   always_comb begin
      logic            legal;
      logic            alt;
      logic [XLEN-1:0] b_val;
      legal = 1'b0;
      alt   = 1'b0;
      b_val = '0;
      case (opcode)
         OPC_OP: begin
            b_val = b_src;
            if (funct7 == F7_ZERO) begin
               legal = 1'b1;
            end else if ((funct7 == F7_ALT) && ((funct3 == 3'b000) || (funct3 == 3'b101))) begin
               legal = 1'b1;
               alt   = 1'b1;
            end
         end
         OPC_OP_IMM: begin
            b_val = imm_sext;
            case (funct3)
               3'b001: legal = (funct7 == F7_ZERO);
               3'b101: begin
                  if (funct7 == F7_ZERO) begin
                     legal = 1'b1;
                  end else if (funct7 == F7_ALT) begin
                     legal = 1'b1;
                     alt   = 1'b1;
                  end
               end
               // ADDI/SLTI/...: instr[30] is immediate data, never a SUB select.
               default: legal = 1'b1;
            endcase
         end
         default: legal = 1'b0;
      endcase

      dec = '0;
      if (legal) begin
         dec.a         = a_src;
         dec.b         = b_val;
         dec.funct3    = funct3;
         dec.funct7_5b = alt;
         dec.rd        = in_instr[11:7];
      end else begin
         dec.illegal   = 1'b1;
      end
   end

   // Output + skid buffer: the skid only fills when the output is stalled, and
   // it always moves forward into the output before any newer op, so order holds.
   always_ff @(posedge clk) begin
      if (reset) begin
         out_q        <= '0;
         skid_q       <= '0;
         out_valid_q  <= 1'b0;
         skid_valid_q <= 1'b0;
      end else if (!out_valid_q || drain) begin
         if (skid_valid_q) begin
            out_q        <= skid_q;
            out_valid_q  <= 1'b1;
            skid_valid_q <= accept;
            if (accept) skid_q <= dec;
         end else if (accept) begin
            out_q       <= dec;
            out_valid_q <= 1'b1;
         end else begin
            out_valid_q <= 1'b0;
         end
      end else if (accept) begin
         skid_q       <= dec;
         skid_valid_q <= 1'b1;
      end
   end

   assign out_valid     = out_valid_q;
   assign out_a         = out_q.a;
   assign out_b         = out_q.b;
   assign out_funct3    = out_q.funct3;
   assign out_funct7_5b = out_q.funct7_5b;
   assign out_rd        = out_q.rd;
   assign out_illegal   = out_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// tb_alu_issue: directed + small random stimulus for alu_issue with an
// expected-result queue checked whenever the DUT hands an op downstream.
module tb_alu_issue;

   typedef struct packed {
      logic [31:0] a;
      logic [31:0] b;
      logic [2:0]  f3;
      logic        f7;
      logic [4:0]  rd;
      logic        ill;
   } exp_t;
   localparam int EW = 74;

   logic        clk = 1'b0;
   logic        reset;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_instr;
   logic [4:0]  rs1_addr;
   logic [4:0]  rs2_addr;
   logic [31:0] rs1_data;
   logic [31:0] rs2_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_a;
   logic [31:0] out_b;
   logic [2:0]  out_funct3;
   logic        out_funct7_5b;
   logic [4:0]  out_rd;
   logic        out_illegal;
`ifdef ALU_ISSUE_FWD_EN
   logic        wb_valid = 1'b0;
   logic [4:0]  wb_rd = 5'd0;
   logic [31:0] wb_data = 32'd0;
`endif

   logic [EW-1:0] exp_q[$];
   int   vectors = 0;
   int   miscompares = 0;
   int   cyc = 0;
   int   pop_cyc = 0;
   int   prev_pop_cyc = 0;
   exp_t last_out = '0;
   exp_t prev_out = '0;

   alu_issue dut (
      .clk(clk), .reset(reset),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
      .rs1_data(rs1_data), .rs2_data(rs2_data),
`ifdef ALU_ISSUE_FWD_EN
      .wb_valid(wb_valid), .wb_rd(wb_rd), .wb_data(wb_data),
`endif
      .out_valid(out_valid), .out_ready(out_ready),
      .out_a(out_a), .out_b(out_b), .out_funct3(out_funct3),
      .out_funct7_5b(out_funct7_5b), .out_rd(out_rd), .out_illegal(out_illegal)
   );

   // clock / cycle counter
   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   // Reference decode written straight from the instruction-set rules.
   function automatic exp_t model(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      exp_t e;
      logic ok;
      logic alt;
      logic [31:0] a;
      logic [31:0] b;
      e = '0; ok = 1'b0; alt = 1'b0; a = r1; b = 32'd0;
`ifdef ALU_ISSUE_FWD_EN
      if (wb_valid && wb_rd != 0 && wb_rd == ins[19:15]) a = wb_data;
      if (wb_valid && wb_rd != 0 && wb_rd == ins[24:20]) r2 = wb_data;
`endif
      if (ins[6:0] == 7'h33) begin
         b = r2;
         if (ins[31:25] == 7'h00) ok = 1'b1;
         if (ins[31:25] == 7'h20 && (ins[14:12] == 3'd0 || ins[14:12] == 3'd5)) begin ok = 1'b1; alt = 1'b1; end
      end else if (ins[6:0] == 7'h13) begin
         b = {{20{ins[31]}}, ins[31:20]};
         if (ins[14:12] == 3'd1) ok = (ins[31:25] == 7'h00);
         else if (ins[14:12] == 3'd5) begin
            ok  = (ins[31:25] == 7'h00) || (ins[31:25] == 7'h20);
            alt = (ins[31:25] == 7'h20);
         end else ok = 1'b1;
      end
      if (ok) begin
         e.a = a; e.b = b; e.f3 = ins[14:12]; e.f7 = alt; e.rd = ins[11:7];
      end else begin
         e.ill = 1'b1;
      end
      return e;
   endfunction

   function automatic logic [31:0] mk_r(input logic [6:0] f7, input logic [4:0] r2, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
      return {f7, r2, r1, f3, rd, 7'h33};
   endfunction

   function automatic logic [31:0] mk_i(input logic [11:0] imm, input logic [4:0] r1,
                                        input logic [2:0] f3, input logic [4:0] rd);
      return {imm, r1, f3, rd, 7'h13};
   endfunction

   // Scoreboard: every downstream transfer pops and checks one expected op.
   always @(negedge clk) begin
      if (!reset && out_valid && out_ready) begin
         exp_t obs;
         exp_t e;
         obs = {out_a, out_b, out_funct3, out_funct7_5b, out_rd, out_illegal};
         vectors++;
         assert (exp_q.size() > 0) else begin
            miscompares++;
            $error("FAIL unexpected_output got rd=%0d a=%h, expected no output", out_rd, out_a);
         end
         if (exp_q.size() > 0) begin
            e = exp_t'(exp_q.pop_front());
            vectors++;
            assert (obs === e) else begin
               miscompares++;
               $error("FAIL out_payload got %h expected %h", obs, e);
            end
         end
         prev_out     = last_out;
         last_out     = obs;
         prev_pop_cyc = pop_cyc;
         pop_cyc      = cyc;
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      vectors++;
      assert (obs === expv) else begin
         miscompares++;
         $error("FAIL %s got %h expected %h", tag, obs, expv);
      end
   endtask

   // Drive one op starting at posedge+1; returns at posedge+1 after acceptance.
   task automatic send(input logic [31:0] ins, input logic [31:0] r1, input logic [31:0] r2);
      int n;
      in_valid = 1'b1; in_instr = ins; rs1_data = r1; rs2_data = r2;
      n = 0;
      @(negedge clk);
      while (!in_ready && n < 50) begin @(negedge clk); n++; end
      vectors++;
      assert (in_ready === 1'b1) else begin
         miscompares++;
         $error("FAIL accept_timeout got in_ready=%b expected 1", in_ready);
      end
      if (in_ready) exp_q.push_back(EW'(model(ins, r1, r2)));
      @(posedge clk); #1;
      in_valid = 1'b0; rs1_data = $urandom; rs2_data = $urandom;
   endtask

   task automatic wait_drain();
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < 100) begin @(posedge clk); #1; n++; end
      @(posedge clk); #1;
      chk("drain_timeout", exp_q.size(), 0);
   endtask

   initial begin
      reset = 1'b1; in_valid = 1'b0; in_instr = '0; rs1_data = '0; rs2_data = '0; out_ready = 1'b0;

      // reset state
      repeat (3) @(posedge clk);
      @(negedge clk);
      chk("rst_out_valid", {31'd0, out_valid}, 0);
      chk("rst_in_ready", {31'd0, in_ready}, 0);
      chk("rst_out_a", out_a, 0);
      chk("rst_out_b", out_b, 0);
      chk("rst_fields", {24'd0, out_funct3, out_funct7_5b, out_rd, out_illegal}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      @(negedge clk);
      chk("post_rst_in_ready", {31'd0, in_ready}, 1);
      chk("rs_addr", {22'd0, rs1_addr, rs2_addr}, 0);
      @(posedge clk); #1;

      // ADD then SUB back to back
      out_ready = 1'b1;
      in_instr = 32'h003100B3; #1;
      chk("rs_addr_add", {22'd0, rs1_addr, rs2_addr}, {22'd0, 5'd2, 5'd3});
      send(32'h003100B3, 32'd10, 32'd3);
      send(32'h403100B3, 32'd10, 32'd3);
      wait_drain();
      chk("add_a", prev_out.a, 32'd10);
      chk("add_b", prev_out.b, 32'd3);
      chk("add_f7", {31'd0, prev_out.f7}, 0);
      chk("sub_f3", {29'd0, last_out.f3}, 0);
      chk("sub_f7", {31'd0, last_out.f7}, 1);
      chk("add_sub_consecutive", pop_cyc - prev_pop_cyc, 1);

      // ADDI sign extension and bit-30 immediates
      send(32'h80010093, 32'd7, 32'd0);
      wait_drain();
      chk("addi_neg_b", last_out.b, 32'hFFFFF800);
      chk("addi_neg_f7", {31'd0, last_out.f7}, 0);
      send(32'h40010093, 32'd7, 32'd0);
      wait_drain();
      chk("addi_400_b", last_out.b, 32'h00000400);
      chk("addi_400_f7", {31'd0, last_out.f7}, 0);

      // SRAI and a bad shift-immediate encoding
      send(32'h40515093, 32'h80000000, 32'd0);
      wait_drain();
      chk("srai_ctl", {27'd0, last_out.f3, last_out.f7, last_out.ill}, {27'd0, 3'b101, 1'b1, 1'b0});
      chk("srai_shamt", {27'd0, last_out.b[4:0]}, 5);
      send(32'h02515093, 32'h80000000, 32'd0);
      wait_drain();
      chk("srai_bad_ill", {31'd0, last_out.ill}, 1);
      chk("srai_bad_zero", last_out.a | last_out.b | {24'd0, last_out.f3, last_out.f7, last_out.rd}, 0);

      // Backpressure: op1 in output, op2 in skid, op3 held upstream
      out_ready = 1'b0;
      send(mk_r(7'h00, 5'd4, 5'd5, 3'd4, 5'd11), 32'h1111, 32'h2222);
      send(mk_i(12'h123, 5'd6, 3'd6, 5'd12), 32'h3333, 32'h0);
      @(negedge clk);
      chk("bp_in_ready_low", {31'd0, in_ready}, 0);
      in_valid = 1'b1; in_instr = mk_r(7'h20, 5'd7, 5'd8, 3'd5, 5'd13); rs1_data = 32'h5555; rs2_data = 32'h6666;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("bp_hold_ready", {31'd0, in_ready}, 0);
         chk("bp_hold_out", {26'd0, out_valid, out_rd}, {26'd0, 1'b1, 5'd11});
         chk("bp_hold_a", out_a, 32'h1111);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(mk_r(7'h20, 5'd7, 5'd8, 3'd5, 5'd13), 32'h5555, 32'h6666);
      wait_drain();
      chk("bp_last_rd", {27'd0, last_out.rd}, 13);
      chk("bp_consecutive", pop_cyc - prev_pop_cyc, 1);

      // Reset with two ops buffered: nothing stale may come out
      out_ready = 1'b0;
      send(mk_r(7'h00, 5'd1, 5'd1, 3'd0, 5'd20), 32'd1, 32'd2);
      send(mk_r(7'h00, 5'd1, 5'd1, 3'd7, 5'd21), 32'd3, 32'd4);
      exp_q.delete();
      reset = 1'b1;
      @(negedge clk);
      chk("mid_rst_in_ready", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      @(negedge clk);
      chk("mid_rst_out_valid", {31'd0, out_valid}, 0);
      chk("mid_rst_in_ready2", {31'd0, in_ready}, 0);
      @(posedge clk); #1;
      reset = 1'b0;
      out_ready = 1'b1;
      @(negedge clk);
      chk("after_rst_in_ready", {31'd0, in_ready}, 1);
      repeat (4) begin
         @(negedge clk);
         chk("after_rst_no_out", {31'd0, out_valid}, 0);
      end
      @(posedge clk); #1;

`ifdef ALU_ISSUE_FWD_EN
      wb_valid = 1'b1; wb_rd = 5'd2; wb_data = 32'h55;
      send(mk_i(12'h000, 5'd2, 3'd0, 5'd1), 32'h11, 32'h0);
      wait_drain();
      chk("fwd_a", last_out.a, 32'h55);
      wb_rd = 5'd0;
      send(mk_i(12'h000, 5'd2, 3'd0, 5'd1), 32'h11, 32'h0);
      wait_drain();
      chk("fwd_x0_a", last_out.a, 32'h11);
      wb_valid = 1'b0;
`endif

      // Random mix of legal and illegal encodings at full rate
      for (int i = 0; i < 24; i++) begin
         logic [31:0] ins;
         logic [6:0]  f7;
         ins = $urandom;
         case ($urandom_range(0, 2))
            0: f7 = 7'h00;
            1: f7 = 7'h20;
            default: f7 = 7'($urandom);
         endcase
         ins[31:25] = f7;
         case ($urandom_range(0, 2))
            0: ins[6:0] = 7'h33;
            1: ins[6:0] = 7'h13;
            default: ins[6:0] = 7'($urandom);
         endcase
         send(ins, $urandom, $urandom);
      end
      wait_drain();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Issue stage that feeds the 32-bit integer ALU.
- Decodes RV32I OP and OP-IMM instructions into the ALU control fields (funct3, funct7_5b) and latches the operands.
- Presents each decoded op through a 2-entry valid/ready skid buffer so ALU-side stalls never drop or reorder instructions.
- Sits between the fetch/regfile-read logic and the ALU/writeback stage.

Parameters:
- XLEN, 32, operand width; only 32 is supported.

Ports:
- clk  in  1  clock; all state updates on the rising edge
- reset  in  1  synchronous, active-high reset
- in_valid  in  1  upstream instruction valid
- in_ready  out  1  stage can accept this cycle
- in_instr  in  32  instruction word
- rs1_addr  out  5  combinational, equals in_instr[19:15]
- rs2_addr  out  5  combinational, equals in_instr[24:20]
- rs1_data  in  32  register-file read data for rs1_addr, valid in the same cycle
- rs2_data  in  32  register-file read data for rs2_addr, valid in the same cycle
- out_valid  out  1  decoded op valid
- out_ready  in  1  ALU/writeback accepts this cycle
- out_a  out  32  ALU operand a
- out_b  out  32  ALU operand b
- out_funct3  out  3  ALU operation select
- out_funct7_5b  out  1  SUB/SRA select
- out_rd  out  5  destination register
- out_illegal  out  1  instruction was not a legal OP/OP-IMM

Behaviour:
- Reset: all state clears while reset is high.
  - out_valid=0; out_a, out_b, out_funct3, out_funct7_5b, out_rd, out_illegal all 0.
  - Skid entry is empty.
  - in_ready=0 while reset is high and 1 in the first cycle after reset deasserts.
- Reset mid-operation: any held entries are discarded with no output.
- Transfers:
  - Input transfer happens on in_valid && in_ready.
  - Output transfer happens on out_valid && out_ready.
  - Zero bubbles: 1 op per cycle sustained while out_ready=1.
- Latency: an accepted op appears on out_* at the next edge when the output register is empty or being drained.
- Storage is an output register plus one skid register:
  - in_ready = !skid_valid. It is a registered flag and has no combinational path from out_ready.
  - If the output register is full and not draining, an accepted op goes to the skid register.
  - When the output register drains, the skid entry moves into it in the same edge; a simultaneous new accept then fills the vacated slot.
  - Order is always preserved.
- out_* are held stable while out_valid=1 and out_ready=0.
- Decode for opcode 0110011 (OP):
  - a=rs1_data, b=rs2_data, funct3=instr[14:12].
  - funct7=instr[31:25]. 0000000 is legal for every funct3 with funct7_5b=0.
  - funct7=0100000 is legal only for funct3 000 (SUB) or 101 (SRA), with funct7_5b=1.
  - Every other funct7 is illegal.
- Decode for opcode 0010011 (OP-IMM):
  - a=rs1_data, b=sign-extended instr[31:20].
  - funct3 001 (SLLI): legal only if instr[31:25]=0.
  - funct3 101: instr[31:25]=0000000 gives SRLI with funct7_5b=0; 0100000 gives SRAI with funct7_5b=1; any other value is illegal.
  - All other funct3 values: funct7_5b is forced to 0 regardless of instr[30]. ADDI must never become SUB.
- Illegal instructions:
  - Any other opcode, or an illegal funct7/shift-immediate encoding, is still accepted and emitted.
  - Emitted with out_illegal=1 and out_a, out_b, out_funct3, out_funct7_5b, out_rd all 0.
- rd = instr[11:7] and passes through unchanged, including x0.
- rs*_data are sampled only at the accept edge.

Optional Feature:
- Macro: ALU_ISSUE_FWD_EN (writeback forwarding).
- With the macro defined:
  - Adds ports wb_valid (in, 1), wb_rd (in, 5), wb_data (in, 32).
  - At the accept edge, if wb_valid && wb_rd!=0 && wb_rd==rs1_addr, the stage captures wb_data in place of rs1_data; the same rule applies to rs2 for OP only.
  - Entries already held in the output or skid register are not updated.
- Without the macro: the wb_* ports are absent and operands always come from rs*_data.

Test Plan:
- ADD then SUB back-to-back with rs1_data=10, rs2_data=3, out_ready=1:
  - instr 0x003100B3, then the same with funct7=0100000.
  - Expect two consecutive out_valid cycles: a=10, b=3, funct3=000, funct7_5b=0, then 1.
- ADDI instr 0x80010093 (imm=-2048, instr[30]=0) and ADDI with imm=0x400 (bit 30 set):
  - Expect b=0xFFFFF800 and b=0x00000400 respectively, funct7_5b=0 for both.
- SRAI x1,x2,5 (instr 0x40515093):
  - Expect funct3=101, funct7_5b=1, b[4:0]=5.
  - The same with instr[31:25]=0000001 → out_illegal=1, all data fields 0.
- Backpressure:
  - Hold out_ready=0 and issue 3 ops.
  - Expect op1 in the output register and op2 in the skid register, in_ready=0 from the cycle after op2 is accepted, and op3 held upstream.
  - Release out_ready → ops 1, 2, 3 emerge in order on consecutive cycles.
- Reset with 2 ops buffered:
  - Expect out_valid=0 and in_ready=0 during reset, in_ready=1 the next cycle, and no stale op emitted.
- ALU_ISSUE_FWD_EN with wb_valid=1, wb_rd=2, wb_data=0x55, rs1_addr=2, rs1_data=0x11:
  - Expect out_a=0x55.
  - With wb_rd=0: expect out_a=0x11.
